core_data_router: RTL and testbench

Routes the single data port of the cv32e40p core in the RedMulE test environment to its downstream targets: the HWPE peripheral port, the stack memory, the shared TCDM port, and a local MMIO region. It is the stage directly downstream of the core's data interface and directly upstream of the redmule_wrap peripheral port and the dummy memories. Each target returns responses in order. The router tracks outstanding transactions in an ID FIFO so that responses return to the core in request order. It also terminates the exit-code and putchar MMIO region locally.

---
 rtl/core_data_router_if.sv | 25 ++
 rtl/core_data_router.sv | 188 ++++++++++++++++++
 tb/tb_core_data_router.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_data_router_if.sv
// core_data_router_if -- core-side data port bundle (cv32e40p OBI-style data bus).
//   data_req/data_gnt         request handshake
//   data_we/data_be           write enable (1 = write), byte enables
//   data_addr/data_wdata      address and write data
//   data_rvalid/data_rdata    in-order response
// master: the core driving requests; slave: the router answering them.
interface core_data_router_if;
  logic        data_req;
  logic        data_gnt;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_rvalid;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata
  );
  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata
  );
endinterface

// File: rtl/core_data_router.sv
// core_data_router -- routes the core data port to periph (0), stack (1),
// tcdm (2) or the local MMIO region (3) and returns responses in request
// order using an ID FIFO of MAX_OUTSTANDING entries.
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   core                  core data port (core_data_router_if.slave)
//   tgt_req_o[2:0]        per-target request, tgt_add_o/tgt_data_o/tgt_wen_o/tgt_be_o broadcast
//   tgt_gnt_i, tgt_r_valid_i, tgt_r_data_i   per-target grant and response
//   exit_code_o, eoc_o    exit-code register and sticky end-of-computation
//   putc_valid_o, putc_char_o   registered putchar pulse
//   err_o                 sticky protocol error (unexpected response)
// Optional: define CORE_DATA_ROUTER_TRACE_EN for simulation trace output.
module core_data_router #(
  parameter int         HWPE_ADDR_BASE_BIT = 20,
  parameter int         MAX_OUTSTANDING    = 2,
  parameter logic [7:0] MMIO_PAGE          = 8'h80
) (
  input  logic              clk_i,
  input  logic              rst_i,
  core_data_router_if.slave core,
  output logic [2:0]        tgt_req_o,
  output logic [31:0]       tgt_add_o,
  output logic [31:0]       tgt_data_o,
  output logic              tgt_wen_o,
  output logic [3:0]        tgt_be_o,
  input  logic [2:0]        tgt_gnt_i,
  input  logic [2:0]        tgt_r_valid_i,
  input  logic [2:0][31:0]  tgt_r_data_i,
  output logic [31:0]       exit_code_o,
  output logic              eoc_o,
  output logic              putc_valid_o,
  output logic [7:0]        putc_char_o,
  output logic              err_o
);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [1:0] ID_PERIPH = 2'd0, ID_STACK = 2'd1, ID_TCDM = 2'd2, ID_MMIO = 2'd3;

  // rd_exit marks an MMIO read of the exit-code register; every other MMIO
  // access answers with zero.
  typedef struct packed {
    logic [1:0] id;
    logic       rd_exit;
  } entry_t;

  entry_t          fifo_q [MAX_OUTSTANDING];
  entry_t          fifo_d [MAX_OUTSTANDING];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     exit_code_q, exit_code_d;
  logic            eoc_q, eoc_d, putc_valid_q, putc_valid_d, err_q, err_d;
  logic [7:0]      putc_char_q, putc_char_d;

  logic [1:0]  sel;
  logic        full, empty, accept, pop, is_mmio, off0, off4;
  logic [2:0]  exp_mask;
  entry_t      head;

  // Decode: first match wins
  always_comb begin
    if (core.data_addr[HWPE_ADDR_BASE_BIT])       sel = ID_PERIPH;
    else if (core.data_addr[31:24] == 8'h00)      sel = ID_STACK;
    else if (core.data_addr[31:24] == MMIO_PAGE)  sel = ID_MMIO;
    else                                          sel = ID_TCDM;
  end

  assign is_mmio = (sel == ID_MMIO);
  assign off0    = (core.data_addr[23:0] == 24'h0);
  assign off4    = (core.data_addr[23:0] == 24'h4);
  assign full    = (count_q == CW'(MAX_OUTSTANDING));
  assign empty   = (count_q == '0);
  assign head    = fifo_q[rd_ptr_q];

  // Issue: full is taken from the registered count, so a pop never
  // bypasses into a same-cycle grant.
  always_comb begin
    tgt_req_o = '0;
    if (core.data_req && !full && !is_mmio) tgt_req_o[sel] = 1'b1;
  end
  assign core.data_gnt = !full && (is_mmio || tgt_gnt_i[sel]);
  assign accept        = core.data_req && core.data_gnt;
  assign tgt_add_o     = core.data_addr;
  assign tgt_data_o    = core.data_wdata;
  assign tgt_wen_o     = !core.data_we;
  assign tgt_be_o      = core.data_be;

  // Response: only the head target may answer; MMIO heads answer locally.
  // An entry is never at the head in its push cycle (it is still being
  // written), which gives the MMIO its one-cycle minimum latency.
  always_comb begin
    exp_mask = '0;
    if (!empty && head.id != ID_MMIO) exp_mask[head.id] = 1'b1;
  end

  always_comb begin
    core.data_rvalid = 1'b0;
    core.data_rdata  = '0;
    case (head.id)
      ID_PERIPH: core.data_rdata = tgt_r_data_i[0];
      ID_STACK:  core.data_rdata = tgt_r_data_i[1];
      ID_TCDM:   core.data_rdata = tgt_r_data_i[2];
      default:   core.data_rdata = head.rd_exit ? exit_code_q : 32'h0;
    endcase
    if (!empty) core.data_rvalid = (head.id == ID_MMIO) || |(tgt_r_valid_i & exp_mask);
  end
  assign pop = core.data_rvalid;

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      fifo_d[wr_ptr_q] = '{id: sel, rd_exit: is_mmio && !core.data_we && off0};
      wr_ptr_d = (wr_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (accept && !pop)      count_d = count_q + 1'b1;
    else if (!accept && pop) count_d = count_q - 1'b1;
  end

  // MMIO side effects take place at accept
  always_comb begin
    exit_code_d  = exit_code_q;
    eoc_d        = eoc_q;
    putc_valid_d = accept && is_mmio && core.data_we && off4;
    putc_char_d  = putc_valid_d ? core.data_wdata[7:0] : putc_char_q;
    if (accept && is_mmio && core.data_we && off0) begin
      exit_code_d = core.data_wdata;
      eoc_d       = 1'b1;
    end
    // Stray responses are dropped (never popped) and flagged
    err_d = err_q || |(tgt_r_valid_i & ~exp_mask);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      exit_code_q  <= 32'hFFFF_FFFF;
      eoc_q        <= 1'b0;
      putc_valid_q <= 1'b0;
      putc_char_q  <= 8'h0;
      err_q        <= 1'b0;
    end else begin
      fifo_q       <= fifo_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      exit_code_q  <= exit_code_d;
      eoc_q        <= eoc_d;
      putc_valid_q <= putc_valid_d;
      putc_char_q  <= putc_char_d;
      err_q        <= err_d;
    end
  end

  assign exit_code_o  = exit_code_q;
  assign eoc_o        = eoc_q;
  assign putc_valid_o = putc_valid_q;
  assign putc_char_o  = putc_char_q;
  assign err_o        = err_q;

`ifdef CORE_DATA_ROUTER_TRACE_EN
  function automatic string tgt_name(input logic [1:0] id);
    case (id)
      ID_PERIPH: return "periph";
      ID_STACK:  return "stack";
      ID_TCDM:   return "tcdm";
      default:   return "mmio";
    endcase
  endfunction

  always @(posedge clk_i) begin
    if (!rst_i) begin
      if (putc_valid_q) $write("%c", putc_char_q);
      if (accept)
        $display("[%0t] router %s addr=%h tgt=%s", $time, core.data_we ? "W" : "R",
                 core.data_addr, tgt_name(sel));
      if (eoc_d && !eoc_q) $display("[%0t] router exit code %h", $time, exit_code_d);
    end
  end
`else
  // Trace disabled: no simulation output.
`endif
endmodule

// File: tb/tb_core_data_router.sv
// Directed bench for core_data_router: decode, ordering, full stall,
// MMIO side effects, protocol errors and asynchronous reset.
module tb_core_data_router;
  logic             clk, rst;
  logic [2:0]       tgt_req, tgt_gnt, tgt_rv;
  logic [31:0]      tgt_add, tgt_data, exit_code;
  logic             tgt_wen, eoc, putc_valid, err;
  logic [3:0]       tgt_be;
  logic [2:0][31:0] tgt_rd;
  logic [7:0]       putc_char;
  int               total = 0;
  int               bad   = 0;

  core_data_router_if bus ();

  core_data_router dut (
    .clk_i(clk), .rst_i(rst), .core(bus),
    .tgt_req_o(tgt_req), .tgt_add_o(tgt_add), .tgt_data_o(tgt_data),
    .tgt_wen_o(tgt_wen), .tgt_be_o(tgt_be), .tgt_gnt_i(tgt_gnt),
    .tgt_r_valid_i(tgt_rv), .tgt_r_data_i(tgt_rd),
    .exit_code_o(exit_code), .eoc_o(eoc), .putc_valid_o(putc_valid),
    .putc_char_o(putc_char), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bus.data_req   = req;
    bus.data_we    = we;
    bus.data_addr  = addr;
    bus.data_wdata = wdata;
  endtask

  // Single read to a memory target answered one cycle after accept
  task automatic mem_read(input string tag, input logic [31:0] addr, input logic [2:0] exp_req,
                          input int k, input logic [31:0] rdata);
    drive(1'b1, 1'b0, addr, 32'h0);
    #1;
    chk({tag, "_req"}, {29'h0, tgt_req}, {29'h0, exp_req});
    chk({tag, "_gnt"}, {31'h0, bus.data_gnt}, 32'h1);
    chk({tag, "_wen"}, {31'h0, tgt_wen}, 32'h1);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tgt_rv    = 3'b000;
    tgt_rv[k] = 1'b1;
    tgt_rd[k] = rdata;
    #1;
    chk({tag, "_rvalid"}, {31'h0, bus.data_rvalid}, 32'h1);
    chk({tag, "_rdata"}, bus.data_rdata, rdata);
    step();
    tgt_rv = 3'b000;
    #1;
    chk({tag, "_drained"}, {31'h0, bus.data_rvalid}, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    tgt_gnt = 3'b111;
    tgt_rv  = 3'b000;
    tgt_rd  = '0;
    bus.data_be = 4'hF;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step(); step();
    // Reset state
    chk("rst_exit", exit_code, 32'hFFFF_FFFF);
    chk("rst_eoc", {31'h0, eoc}, 32'h0);
    chk("rst_putc", {31'h0, putc_valid}, 32'h0);
    chk("rst_char", {24'h0, putc_char}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_rvalid", {31'h0, bus.data_rvalid}, 32'h0);
    rst = 1'b0;
    step();

    // Decode
    mem_read("periph", 32'h0010_0000, 3'b001, 0, 32'hAAAA_0000);
    mem_read("stack",  32'h0000_1000, 3'b010, 1, 32'h1111_0001);
    mem_read("tcdm",   32'h1C01_0000, 3'b100, 2, 32'h2222_0002);
    drive(1'b1, 1'b0, 32'h8000_0000, 32'h0);
    #1;
    chk("mmio_req", {29'h0, tgt_req}, 32'h0);
    chk("mmio_gnt", {31'h0, bus.data_gnt}, 32'h1);
    chk("mmio_rv_early", {31'h0, bus.data_rvalid}, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("mmio_rvalid", {31'h0, bus.data_rvalid}, 32'h1);
    chk("mmio_rdata", bus.data_rdata, 32'hFFFF_FFFF);
    step();
    chk("mmio_drained", {31'h0, bus.data_rvalid}, 32'h0);

    // Ordering: tcdm read then MMIO read; MMIO waits behind tcdm
    drive(1'b1, 1'b0, 32'h1C01_0000, 32'h0);
    step();
    drive(1'b1, 1'b0, 32'h8000_0000, 32'h0);
    #1;
    chk("ord_gnt2", {31'h0, bus.data_gnt}, 32'h1);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("ord_wait1", {31'h0, bus.data_rvalid}, 32'h0);
    step();
    chk("ord_wait2", {31'h0, bus.data_rvalid}, 32'h0);
    step();
    tgt_rv = 3'b100;
    tgt_rd[2] = 32'hC0DE_0002;
    #1;
    chk("ord_rv1", {31'h0, bus.data_rvalid}, 32'h1);
    chk("ord_rd1", bus.data_rdata, 32'hC0DE_0002);
    step();
    tgt_rv = 3'b000;
    #1;
    chk("ord_rv2", {31'h0, bus.data_rvalid}, 32'h1);
    chk("ord_rd2", bus.data_rdata, 32'hFFFF_FFFF);
    step();
    chk("ord_drained", {31'h0, bus.data_rvalid}, 32'h0);

    // Full: two stack reads outstanding, responses withheld
    drive(1'b1, 1'b0, 32'h0000_1000, 32'h0);
    step(); step();
    chk("full_gnt", {31'h0, bus.data_gnt}, 32'h0);
    chk("full_req", {29'h0, tgt_req}, 32'h0);
    tgt_rv = 3'b010;
    tgt_rd[1] = 32'h5151_0001;
    #1;
    chk("full_rv", {31'h0, bus.data_rvalid}, 32'h1);
    chk("full_nobypass", {31'h0, bus.data_gnt}, 32'h0);
    step();
    tgt_rv = 3'b000;
    #1;
    chk("full_gnt_back", {31'h0, bus.data_gnt}, 32'h1);
    chk("full_req_back", {29'h0, tgt_req}, 32'h2);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tgt_rv = 3'b010;
    tgt_rd[1] = 32'h5151_0002;
    #1;
    chk("full_rv2", bus.data_rdata, 32'h5151_0002);
    step();
    tgt_rv = 3'b000;
    #1;
    chk("full_drained", {31'h0, bus.data_rvalid}, 32'h0);

    // MMIO side effects
    drive(1'b1, 1'b1, 32'h8000_0004, 32'h0000_0041);
    #1;
    chk("putc_before", {31'h0, putc_valid}, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("putc_valid", {31'h0, putc_valid}, 32'h1);
    chk("putc_char", {24'h0, putc_char}, 32'h41);
    chk("putc_rv", {31'h0, bus.data_rvalid}, 32'h1);
    chk("putc_rdata", bus.data_rdata, 32'h0);
    step();
    chk("putc_pulse_end", {31'h0, putc_valid}, 32'h0);
    drive(1'b1, 1'b1, 32'h8000_0000, 32'h0000_005A);
    #1;
    chk("eoc_before", {31'h0, eoc}, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("eoc_set", {31'h0, eoc}, 32'h1);
    chk("exit_5a", exit_code, 32'h5A);
    step();
    drive(1'b1, 1'b0, 32'h8000_0000, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("exit_read", bus.data_rdata, 32'h5A);
    step();
    drive(1'b1, 1'b1, 32'h8000_0000, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("exit_zero", exit_code, 32'h0);
    chk("eoc_sticky", {31'h0, eoc}, 32'h1);
    step();

    // Error: periph answers while head is tcdm
    drive(1'b1, 1'b0, 32'h1C01_0000, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tgt_rv = 3'b001;
    #1;
    chk("err_drop", {31'h0, bus.data_rvalid}, 32'h0);
    step();
    tgt_rv = 3'b100;
    tgt_rd[2] = 32'h7777_0002;
    #1;
    chk("err_set", {31'h0, err}, 32'h1);
    chk("err_head_kept", bus.data_rdata, 32'h7777_0002);
    step();
    tgt_rv = 3'b000;

    // Asynchronous reset with two outstanding
    drive(1'b1, 1'b0, 32'h0000_1000, 32'h0);
    step(); step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_err", {31'h0, err}, 32'h0);
    chk("arst_eoc", {31'h0, eoc}, 32'h0);
    chk("arst_exit", exit_code, 32'hFFFF_FFFF);
    chk("arst_gnt", {31'h0, bus.data_gnt}, 32'h1);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    rst = 1'b0;
    // Late response after reset
    tgt_rv = 3'b010;
    #1;
    chk("late_rv", {31'h0, bus.data_rvalid}, 32'h0);
    step();
    tgt_rv = 3'b000;
    #1;
    chk("late_err", {31'h0, err}, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_read("post_rst", 32'h0000_2000, 3'b010, 1, 32'h3333_0001);
    chk("post_rst_err", {31'h0, err}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
